// File: rtl/uart_term_pkg.sv
// Purpose: shared FSM state encoding, parity mode constants and parity helper for the UART terminal core.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package uart_term_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Parity bit to send or expect; unused upper data bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with an extra pointer wrap bit to tell full from empty.
// Latency: a push is visible at o_data/o_empty the cycle after it is accepted.
// Backpressure: push is dropped when full unless a pop happens the same cycle; pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify requests and advance pointers; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        do_pop   = i_pop && !o_empty;
        do_push  = i_push && (!o_full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/uart_term_core.sv
// Purpose: UART terminal core - synchronised RX deframer, TX framer, RX/TX FIFOs, optional echo loopback.
// Latency: good RX byte pushed the cycle after its stop-bit sample; TX start bit one cycle after a FIFO entry appears.
// Backpressure: o_tx_ready drops when TX FIFO full or an echo push owns the cycle; RX overflow drops the byte and sets o_rx_overrun.
module uart_term_core
    import uart_term_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic                 o_tx,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    input  logic                 i_echo,
    output logic                 o_tx_active,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_rx_overrun
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------- RX state ----------------
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic                 rx_prev_q, rx_prev_d;
    uart_state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           rx_ext;
    logic                 par_bad;
    logic                 rx_full;
    logic                 rx_empty;

    // ---------------- TX state ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic [7:0]           tx_ext;
    logic                 tx_pop;
    logic                 tx_push;
    logic [DATA_BITS-1:0] tx_push_data;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 echo_req;

    // RX deframer: sync chain, start glitch reject, mid-bit sampling, error classification.
    always_comb begin
        rx_meta_d    = i_rx;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + CW'(1);
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        rx_ext       = '0;
        rx_ext[DATA_BITS-1:0] = rx_shift_q;
        par_bad      = (PARITY != PARITY_NONE) && (rx_par_q != parity_bit(rx_ext, PARITY));
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == BAUD_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = ST_IDLE;
                    frame_err_d  = !rx_sync_q;
                    parity_err_d = par_bad;
                    rx_done_d    = rx_sync_q && !par_bad;
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = ST_IDLE;
            end
        endcase
        // A full RX FIFO only takes the byte if the head is popped the same cycle.
        overrun_d = overrun_q || (rx_done_q && rx_full && !i_rx_ready);
    end

    // RX registers; the sync chain resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // TX FIFO write arbitration: an echoed byte wins the cycle over the user port.
    always_comb begin
        echo_req     = i_echo && rx_done_q;
        o_tx_ready   = !tx_full && !echo_req;
        tx_push      = (echo_req && !tx_full) || (i_tx_valid && o_tx_ready);
        tx_push_data = echo_req ? rx_shift_q : i_tx_data;
    end

    // TX framer: pops the FIFO head and serialises start, data LSB first, optional parity, stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_ext     = '0;
        tx_ext[DATA_BITS-1:0] = tx_head;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
            end
            ST_START: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_d       = tx_par_q;
                            tx_state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            tx_state_d = ST_STOP;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = 1'b1;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase
        // Load the next byte from IDLE or straight out of a finished stop bit, so frames abut.
        if ((tx_state_d == ST_IDLE) && !tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = parity_bit(tx_ext, PARITY);
            tx_cnt_d   = '0;
            tx_d       = 1'b0;
            tx_state_d = ST_START;
        end
    end

    // TX registers; the line idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_done_q),
        .i_data  (rx_shift_q),
        .o_full  (rx_full),
        .i_pop   (i_rx_ready),
        .o_data  (o_rx_data),
        .o_empty (rx_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_push),
        .i_data  (tx_push_data),
        .o_full  (tx_full),
        .i_pop   (tx_pop),
        .o_data  (tx_head),
        .o_empty (tx_empty)
    );

    assign o_tx         = tx_q;
    assign o_tx_active  = (tx_state_q != ST_IDLE);
    assign o_rx_valid   = !rx_empty;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_rx_overrun = overrun_q;

endmodule
